// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: one-cycle registered fetch with misaligned/out-of-range faults.
// Optional write port for program loading is enabled by defining IMEM_LOAD_PORT_EN.
module instr_fetch_mem #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 64,
    parameter int                 ADDR_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = 32'h0000_0013,
    localparam int                IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_fault,
    output logic [ADDR_W-1:0] rsp_addr,
`ifdef IMEM_LOAD_PORT_EN
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
`endif
    input  logic              flush
);

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE = 2'b10;

    // One extra bit keeps the bound exact even when 4*DEPTH fills ADDR_W.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH);

    logic              fire;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] nxt_instr;
    logic [1:0]        nxt_fault;

`ifdef IMEM_LOAD_PORT_EN
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

    assign rd_idx = req_addr[IDX_W+1:2];

    // Read is combinational from the pre-edge array, so a same-cycle load returns old data.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
    end

    assign rd_word = mem[rd_idx];
`else
    assign rd_word = NOP_WORD;
`endif

    assign req_ready = rst_n & (~rsp_valid | rsp_ready);
    assign fire      = req_valid & req_ready;

    always_comb begin
        nxt_instr = '0;
        nxt_fault = FLT_NONE;
        if (req_addr[1:0] != 2'b00) begin
            nxt_fault = FLT_ALIGN;
        end else if ({1'b0, req_addr} >= LIMIT) begin
            nxt_fault = FLT_RANGE;
        end else begin
            nxt_instr = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_fault <= FLT_NONE;
            rsp_addr  <= '0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_instr <= nxt_instr;
            rsp_fault <= nxt_fault;
            rsp_addr  <= req_addr;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem; load-port scenarios run when IMEM_LOAD_PORT_EN is defined.
module tb_instr_fetch_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [1:0]        rsp_fault;
    logic [ADDR_W-1:0] rsp_addr;
    logic              flush;
`ifdef IMEM_LOAD_PORT_EN
    logic              ld_en;
    logic [5:0]        ld_idx;
    logic [DATA_W-1:0] ld_data;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] instr;
        logic [1:0]        fault;
    } rsp_t;

    rsp_t              sb[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                checks = 0;
    int                errors = 0;

    instr_fetch_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_fault(rsp_fault), .rsp_addr(rsp_addr),
`ifdef IMEM_LOAD_PORT_EN
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
`endif
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rsp_t model(input logic [ADDR_W-1:0] a);
        rsp_t r;
        r.addr  = a;
        r.instr = '0;
        r.fault = 2'b00;
        if (a[1:0] != 2'b00)            r.fault = 2'b01;
        else if (a >= 32'(4 * DEPTH))   r.fault = 2'b10;
        else                            r.instr = model_mem[a[7:2]];
        return r;
    endfunction

    task automatic push(input logic [ADDR_W-1:0] a);
        sb.push_back(model(a));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_instr !== '0 || rsp_fault !== 2'b00 || rsp_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h fault=%b addr=%h, want 0/0/00/0",
                     rsp_valid, rsp_instr, rsp_fault, rsp_addr);
        end
        req_valid = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b rsp_valid=%b, want 0/0", req_ready, rsp_valid);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
    endtask

    // Drive a list of fetches back to back; each response is compared the cycle after its fire.
    task automatic run_seq(input string name, input logic [ADDR_W-1:0] addrs[]);
        rsp_t e;
        foreach (addrs[i]) begin
            req_valid = 1'b1;
            req_addr  = addrs[i];
            push(addrs[i]);
            step();
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s_sb_empty: idx %0d", name, i);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== 1'b1 || rsp_addr !== e.addr || rsp_instr !== e.instr || rsp_fault !== e.fault) begin
                    errors++;
                    $display("FAIL %s[%0d]: valid=%b addr=%h instr=%h fault=%b, want 1 %h %h %b",
                             name, i, rsp_valid, rsp_addr, rsp_instr, rsp_fault, e.addr, e.instr, e.fault);
                end
            end
        end
        req_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: rsp_valid=%b want 0", name, rsp_valid);
        end
    endtask

`ifdef IMEM_LOAD_PORT_EN
    task automatic test_load();
        ld_en = 1'b1; ld_idx = 6'd0; ld_data = 32'h0020_81B3;
        step();
        model_mem[0] = 32'h0020_81B3;
        ld_en = 1'b0;
        run_seq("load_fetch", '{32'h0});
        // Same-cycle load and fetch of word 1: fetch sees the old word, the next one the new word.
        ld_en = 1'b1; ld_idx = 6'd1; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h4;
        push(32'h4);
        step();
        ld_en = 1'b0;
        model_mem[1] = 32'hDEAD_BEEF;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_instr !== sb[0].instr) begin
            errors++;
            $display("FAIL rbw_old: valid=%b instr=%h want 1 %h", rsp_valid, rsp_instr, sb[0].instr);
        end
        void'(sb.pop_front());
        req_valid = 1'b0;
        step();
        run_seq("rbw_new", '{32'h4});
    endtask
`endif

    task automatic test_faults();
        run_seq("faults", '{32'h6, 32'h100, 32'hFC, 32'h101, 32'h1, 32'hFFFF_FFFC});
    endtask

    task automatic test_back_to_back();
        run_seq("b2b", '{32'h0, 32'h4, 32'h8});
    endtask

    task automatic test_backpressure();
        rsp_t e;
        logic [DATA_W-1:0] held_instr;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8;
        push(32'h8);
        step();
        held_instr = rsp_instr;
        req_addr = 32'hC;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_addr !== 32'h8 ||
                rsp_instr !== sb[0].instr || rsp_instr !== held_instr || rsp_fault !== 2'b00) begin
                errors++;
                $display("FAIL stall[%0d]: ready=%b valid=%b addr=%h instr=%h fault=%b, want 0 1 00000008 %h 00",
                         c, req_ready, rsp_valid, rsp_addr, rsp_instr, rsp_fault, sb[0].instr);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b want 1", req_ready);
        end
        e = sb.pop_front();
        push(32'hC);
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 32'hC || rsp_instr !== sb[0].instr) begin
            errors++;
            $display("FAIL stall_next: valid=%b addr=%h instr=%h, want 1 0000000c %h (prev %h)",
                     rsp_valid, rsp_addr, rsp_instr, sb[0].instr, e.addr);
        end
        void'(sb.pop_front());
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        req_valid = 1'b1; req_addr = 32'h10; flush = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_fire: rsp_valid=%b want 0", rsp_valid);
        end
        flush = 1'b0;
        rsp_ready = 1'b0;
        req_addr = 32'h14;
        push(32'h14);
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_addr !== 32'h14) begin
            errors++;
            $display("FAIL flush_setup: valid=%b addr=%h want 1 00000014", rsp_valid, rsp_addr);
        end
        void'(sb.pop_front());
        flush = 1'b1;
        step();
        flush = 1'b0;
        rsp_ready = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_held: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 32'h18;
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: rsp_valid=%b want 1", rsp_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_instr !== '0 || rsp_addr !== '0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: valid=%b instr=%h addr=%h ready=%b, want 0 0 0 0",
                     rsp_valid, rsp_instr, rsp_addr, req_ready);
        end
        step();
        rst_n = 1'b1;
        req_valid = 1'b1; req_addr = 32'h4;
        push(32'h4);
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_addr !== sb[0].addr || rsp_instr !== sb[0].instr) begin
            errors++;
            $display("FAIL first_fire_after_reset: valid=%b addr=%h instr=%h, want 1 %h %h",
                     rsp_valid, rsp_addr, rsp_instr, sb[0].addr, sb[0].instr);
        end
        void'(sb.pop_front());
        step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
`ifdef IMEM_LOAD_PORT_EN
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
`endif
        test_reset();
`ifdef IMEM_LOAD_PORT_EN
        test_load();
`endif
        test_faults();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of instruction words; power of two, at least 4.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter NOP_WORD, default 32'h0000_0013, initial content of every word.
REQ-005 SHALL have port clk, input, 1, single clock; all state is updated on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, fetch request present.
REQ-008 SHALL have port req_ready, output, 1, fetch request accepted this cycle.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address of the fetch (PC).
REQ-010 SHALL have port rsp_valid, output, 1, response held in the output register.
REQ-011 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-012 SHALL have port rsp_instr, output, DATA_W, fetched instruction.
REQ-013 SHALL have port rsp_fault, output, 2, fault code: 00 none, 01 misaligned, 10 out of range.
REQ-014 SHALL have port rsp_addr, output, ADDR_W, byte address of the response.
REQ-015 SHALL have port flush, input, 1, discards any held or accepted response (redirect).

Function
REQ-016 SHALL accept a request when req_valid and req_ready are both 1 (the fire condition).
REQ-017 SHALL drive req_ready = !rsp_valid | rsp_ready; it SHALL be 0 during reset.
REQ-018 SHALL register the response one cycle after a fire: latency 1, throughput 1 per cycle with rsp_ready held at 1.
REQ-019 SHALL read the word at index req_addr[log2(DEPTH)+1:2].
REQ-020 SHALL set rsp_fault=01 and rsp_instr=0 when req_addr[1:0] != 0.
REQ-021 SHALL set rsp_fault=10 and rsp_instr=0 when req_addr >= 4*DEPTH and the address is aligned; misaligned takes priority over out of range.
REQ-022 SHALL hold rsp_valid, rsp_instr, rsp_fault and rsp_addr stable while rsp_valid=1 and rsp_ready=0.
REQ-023 SHALL clear rsp_valid when rsp_ready=1 and no fire occurs in the same cycle.
REQ-024 SHALL load the new response when a fire and a response consume happen in the same cycle, keeping rsp_valid at 1.
REQ-025 SHALL force rsp_valid to 0 on the next edge when flush=1, regardless of fire or rsp_ready; a request accepted in the flush cycle is discarded.
REQ-026 SHALL wrap nothing: the index is never taken modulo DEPTH for out-of-range addresses.

Reset
REQ-027 SHALL, while rst_n=0, immediately set rsp_valid=0, rsp_instr=0, rsp_fault=00 and rsp_addr=0.
REQ-028 SHALL leave memory contents unaffected by reset; at time zero every word SHALL equal NOP_WORD.
REQ-029 SHALL drop any in-flight response when reset is asserted mid-operation; the first fire after reset release SHALL occur at the earliest on the first rising edge with rst_n=1.

Configuration
REQ-030 SHALL provide macro IMEM_LOAD_PORT_EN; when it is defined, the module SHALL add inputs ld_en (1), ld_idx (log2 DEPTH) and ld_data (DATA_W), and each rising edge with ld_en=1 SHALL write ld_data to word ld_idx.
REQ-031 SHALL, with IMEM_LOAD_PORT_EN defined, give a same-cycle fetch of word ld_idx the old data (read-before-write); the new data SHALL be visible on the following fetch.
REQ-032 SHALL, without IMEM_LOAD_PORT_EN, have no load ports, and the memory SHALL be read-only with NOP_WORD contents.

Verification
REQ-033 SHALL cover: load word 0 with 32'h002081B3 (add x3,x1,x2), fetch addr 0 -> next cycle rsp_valid=1, rsp_instr=32'h002081B3, rsp_fault=00.
REQ-034 SHALL cover: fetch addr 0x6 -> rsp_fault=01, rsp_instr=0; fetch addr 0x100 with DEPTH=64 -> rsp_fault=10, rsp_instr=0.
REQ-035 SHALL cover: rsp_ready=0 for 3 cycles after a response -> req_ready=0 and outputs stable; rsp_ready=1 -> the next request is accepted the same cycle.
REQ-036 SHALL cover: back-to-back fetches at 0x0, 0x4, 0x8 with rsp_ready=1 -> 3 consecutive valid responses carrying rsp_addr 0x0, 0x4, 0x8.
REQ-037 SHALL cover: flush asserted in the same cycle as a fire -> rsp_valid=0 on the next cycle.
REQ-038 SHALL cover: rst_n dropped while rsp_valid=1 -> rsp_valid=0 immediately, without waiting for a clock edge.
